dp_sched: RTL and testbench

Sequencing controller for the dual-array DP engine. Accepts one sequence-pair job at a time from the host, then drives the engine's `new_seq`, `s_update`/`S`, `valid`/`T` and `ack` pins in the fixed order the engine requires. It streams S and T bases from two ready/valid host streams and honours engine backpressure (`busy`). It sits between the host/DMA front end and the DP top level, and is the only block that drives DP input pins.

---
 rtl/dp_sched.sv | 131 +++++++++++++
 tb/tb_dp_sched.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_sched.sv
// dp_sched: sequencing controller that feeds one S/T sequence-pair job at a time
// into the dual-array DP engine and owns every engine input pin.
module dp_sched #(
   parameter int BP_WIDTH  = 2,
   parameter int N         = 64,
   parameter int LEN_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_i,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] s_len,
   input  logic [LEN_WIDTH-1:0] t_len,
   input  logic [BP_WIDTH-1:0]  s_in_data,
   input  logic                 s_in_valid,
   output logic                 s_in_ready,
   input  logic [BP_WIDTH-1:0]  t_in_data,
   input  logic                 t_in_valid,
   output logic                 t_in_ready,
   output logic                 new_seq,
   output logic [BP_WIDTH-1:0]  S,
   output logic                 s_update,
   output logic [BP_WIDTH-1:0]  T,
   output logic                 valid,
   input  logic                 busy,
   output logic                 ack,
   output logic                 sched_busy,
   output logic                 done,
   output logic                 err,
   output logic [LEN_WIDTH-1:0] job_cnt
);

   typedef enum logic [2:0] {
      IDLE, NEWSEQ, LOAD_S, STREAM_T, DRAIN, ACK, DONE
   } state_t;

   state_t               state, state_nxt;
   logic [LEN_WIDTH-1:0] s_len_q, t_len_q, s_cnt, t_cnt;
   logic                 len_ok, accept, s_xfer, t_xfer, s_last, t_last;
   logic                 drain_first, err_nxt;

   assign len_ok = (s_len != '0) && (s_len <= LEN_WIDTH'(N)) && (t_len != '0);
   assign accept = (state == IDLE) && start && len_ok;
   assign s_xfer = (state == LOAD_S) && s_in_valid;
   assign t_xfer = (state == STREAM_T) && t_in_valid && !busy;
   assign s_last = (s_cnt == s_len_q - LEN_WIDTH'(1));
   assign t_last = (t_cnt == t_len_q - LEN_WIDTH'(1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) state <= IDLE;
      else          state <= state_nxt;
   end

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt  = state;
      err_nxt    = 1'b0;
      s_in_ready = 1'b0;
      s_update   = 1'b0;
      S          = '0;
      t_in_ready = 1'b0;
      valid      = 1'b0;
      T          = '0;
      case (state)
         IDLE: begin
            if (start && len_ok)  state_nxt = NEWSEQ;
            else if (start)       err_nxt   = 1'b1;
         end
         NEWSEQ: state_nxt = LOAD_S;
         LOAD_S: begin
            s_in_ready = 1'b1;
            s_update   = s_in_valid;
            S          = s_in_data;
            if (s_xfer && s_last) state_nxt = STREAM_T;
         end
         STREAM_T: begin
            t_in_ready = !busy;
            valid      = t_in_valid && !busy;
            T          = t_in_data;
            if (t_xfer && t_last) state_nxt = DRAIN;
         end
         // The engine may only raise busy a cycle after the last base, so the
         // first DRAIN cycle never looks at it.
         DRAIN:   if (!drain_first && !busy) state_nxt = ACK;
         ACK:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         s_len_q     <= '0;
         t_len_q     <= '0;
         s_cnt       <= '0;
         t_cnt       <= '0;
         drain_first <= 1'b0;
      end else begin
         if (accept) begin
            s_len_q <= s_len;
            t_len_q <= t_len;
            s_cnt   <= '0;
            t_cnt   <= '0;
         end else begin
            if (s_xfer) s_cnt <= s_cnt + LEN_WIDTH'(1);
            if (t_xfer) t_cnt <= t_cnt + LEN_WIDTH'(1);
         end
         drain_first <= (state != DRAIN);
      end
   end

   // Registered strobes are decoded from the next state so they line up with it.
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         new_seq    <= 1'b0;
         ack        <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         sched_busy <= 1'b0;
         job_cnt    <= '0;
      end else begin
         new_seq    <= (state_nxt == NEWSEQ);
         ack        <= (state_nxt == ACK);
         done       <= (state_nxt == DONE);
         err        <= err_nxt;
         sched_busy <= (state_nxt != IDLE);
         if (state_nxt == DONE) job_cnt <= job_cnt + LEN_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_dp_sched.sv
// tb_dp_sched: scoreboard bench for dp_sched; host streams feed queued bases,
// engine-side monitor pops the expected bases and counts every strobe.
module tb_dp_sched;

   localparam int BPW = 2;
   localparam int NP  = 8;
   localparam int LW  = 16;

   logic           clk;
   logic           reset_i;
   logic           start;
   logic [LW-1:0]  s_len, t_len;
   logic [BPW-1:0] s_in_data, t_in_data;
   logic           s_in_valid, s_in_ready, t_in_valid, t_in_ready;
   logic           new_seq, s_update, valid, busy, ack, sched_busy, done, err;
   logic [BPW-1:0] S, T;
   logic [LW-1:0]  job_cnt;

   dp_sched #(.BP_WIDTH(BPW), .N(NP), .LEN_WIDTH(LW)) dut (
      .clk(clk), .reset_i(reset_i), .start(start), .s_len(s_len), .t_len(t_len),
      .s_in_data(s_in_data), .s_in_valid(s_in_valid), .s_in_ready(s_in_ready),
      .t_in_data(t_in_data), .t_in_valid(t_in_valid), .t_in_ready(t_in_ready),
      .new_seq(new_seq), .S(S), .s_update(s_update), .T(T), .valid(valid),
      .busy(busy), .ack(ack), .sched_busy(sched_busy), .done(done), .err(err),
      .job_cnt(job_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   logic [BPW-1:0] s_src[$], t_src[$];   // bases the host still has to offer
   logic [BPW-1:0] s_exp[$], t_exp[$];   // bases the engine still has to see
   logic [BPW-1:0] mon_b;

   int new_seq_cnt, s_upd_cnt, t_val_cnt, ack_cnt, done_cnt, err_cnt;
   int cyc = 0, sb_cyc = 0, ack_cyc = 0, done_cyc = 0, cur_sl = 0, exp_jobs = 0;
   bit t_seen, sb_prev, busy_prev, s_stall, t_stall, s_phase, t_phase;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] out_vec();
      return 32'({job_cnt, new_seq, S, s_update, T, valid, ack,
                  s_in_ready, t_in_ready, sched_busy, done, err});
   endfunction

   // Host stream drivers: offer the queue head, optionally every other cycle.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         s_phase    = ~s_phase;
         t_phase    = ~t_phase;
         s_in_valid = (s_src.size() != 0) && (!s_stall || s_phase);
         s_in_data  = s_in_valid ? s_src[0] : BPW'($urandom);
         t_in_valid = (t_src.size() != 0) && (!t_stall || t_phase);
         t_in_data  = t_in_valid ? t_src[0] : BPW'($urandom);
      end
   end

   // Engine-side monitor, sampled mid-cycle.
   always @(negedge clk) begin
      cyc++;
      if (!sched_busy)
         check("idle_outputs_zero",
               32'({S, T, valid, s_update, s_in_ready, t_in_ready, new_seq, ack, done}), 0);
      if (s_update) begin
         s_upd_cnt++;
         check("s_update_needs_valid", 32'(s_in_valid), 1);
         if (s_exp.size() != 0) begin
            mon_b = s_exp.pop_front();
            check("S_data", 32'(S), 32'(mon_b));
         end else check("s_overrun", s_upd_cnt, cur_sl);
      end
      if (valid) begin
         t_val_cnt++;
         check("valid_needs_t_valid", 32'(t_in_valid), 1);
         if (t_exp.size() != 0) begin
            mon_b = t_exp.pop_front();
            check("T_data", 32'(T), 32'(mon_b));
         end else check("t_overrun", t_val_cnt, 0);
      end
      if (s_in_valid && s_in_ready && s_src.size() != 0) mon_b = s_src.pop_front();
      if (t_in_valid && t_in_ready && t_src.size() != 0) mon_b = t_src.pop_front();
      if (busy && sched_busy) begin
         check("bp_valid_low", 32'(valid), 0);
         check("bp_t_ready_low", 32'(t_in_ready), 0);
      end
      if (t_in_ready && !t_seen) begin
         t_seen = 1'b1;
         check("s_xfers_before_t", s_upd_cnt, cur_sl);
      end
      if (new_seq) new_seq_cnt++;
      if (ack) begin
         ack_cnt++;
         ack_cyc = cyc;
         check("ack_after_busy_low", 32'(busy_prev), 0);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (err) err_cnt++;
      if (sched_busy && !sb_prev) sb_cyc = cyc;
      sb_prev   = sched_busy;
      busy_prev = busy;
   end

   task automatic load_job(input int sl, input int tl);
      logic [BPW-1:0] b;
      for (int i = 0; i < sl; i++) begin
         b = BPW'($urandom);
         s_src.push_back(b);
         s_exp.push_back(b);
      end
      for (int i = 0; i < tl; i++) begin
         b = BPW'($urandom);
         t_src.push_back(b);
         t_exp.push_back(b);
      end
      cur_sl      = sl;
      new_seq_cnt = 0;
      s_upd_cnt   = 0;
      t_val_cnt   = 0;
      ack_cnt     = 0;
      done_cnt    = 0;
      err_cnt     = 0;
      t_seen      = 1'b0;
   endtask

   // Entered and left at posedge+1. With chain set, start is raised during
   // DONE and left high into the following IDLE cycle.
   task automatic run_job(input int sl, input int tl, input bit stall, input int bp,
                          input bit chain);
      int bp1, bp2;
      bp1 = bp;
      bp2 = bp;
      load_job(sl, tl);
      s_stall = stall;
      t_stall = stall;
      s_len   = LW'(sl);
      t_len   = LW'(tl);
      start   = 1'b1;
      @(negedge clk);
      check("idle_before_start", 32'(sched_busy), 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("new_seq_latency", 32'(new_seq), 1);
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         busy = 1'b0;
         if (bp > 0) begin
            if (t_val_cnt >= 2 && bp1 > 0) begin
               busy = 1'b1;
               bp1--;
            end else if (t_val_cnt == tl && bp2 > 0) begin
               busy = 1'b1;
               bp2--;
            end
         end
         if (chain && ack_cnt != 0 && done_cnt == 0) begin
            start = 1'b1;
            s_len = LW'(1);
            t_len = LW'(1);
         end
         if (done_cnt != 0) break;
      end
      busy = 1'b0;
      exp_jobs++;
      check("job_done_seen", done_cnt, 1);
      check("new_seq_once", new_seq_cnt, 1);
      check("s_update_count", s_upd_cnt, sl);
      check("valid_count", t_val_cnt, tl);
      check("ack_once", ack_cnt, 1);
      check("done_after_ack", done_cyc - ack_cyc, 1);
      check("no_err_in_job", err_cnt, 0);
      check("s_exp_empty", s_exp.size(), 0);
      check("t_exp_empty", t_exp.size(), 0);
      check("job_cnt", 32'(job_cnt), exp_jobs);
      if (sl == 1 && tl == 1 && !stall && bp == 0)
         check("min_job_cycles", done_cyc - sb_cyc, 6);
   endtask

   task automatic try_illegal(input int sl, input int tl);
      err_cnt     = 0;
      new_seq_cnt = 0;
      s_len       = LW'(sl);
      t_len       = LW'(tl);
      start       = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("err_next_cycle", 32'(err), 1);
      repeat (3) @(posedge clk);
      #1;
      check("err_once", err_cnt, 1);
      check("illegal_no_new_seq", new_seq_cnt, 0);
      check("illegal_stays_idle", 32'(sched_busy), 0);
      check("illegal_job_cnt", 32'(job_cnt), exp_jobs);
   endtask

   initial begin
      reset_i    = 1'b1;
      start      = 1'b0;
      busy       = 1'b0;
      s_len      = '0;
      t_len      = '0;
      s_in_valid = 1'b0;
      t_in_valid = 1'b0;
      s_in_data  = '0;
      t_in_data  = '0;
      #1 reset_i = 1'b0;
      #2 check("reset_outputs", out_vec(), 0);
      repeat (2) @(posedge clk);
      #1 reset_i = 1'b1;
      @(posedge clk);
      #1;

      run_job(4, 6, 1'b0, 0, 1'b0);      // basic job
      run_job(1, 1, 1'b0, 0, 1'b0);      // minimum job
      run_job(4, 6, 1'b0, 3, 1'b0);      // backpressure mid-T and in DRAIN
      try_illegal(0, 1);
      try_illegal(NP + 1, 1);
      try_illegal(1, 0);
      run_job(NP, 3, 1'b0, 0, 1'b0);     // s_len at its maximum
      run_job(5, 4, 1'b1, 0, 1'b0);      // host stalls every other cycle
      run_job(3, 2, 1'b0, 0, 1'b1);      // start raised during DONE
      run_job(2, 3, 1'b0, 0, 1'b0);

      // Reset during STREAM_T aborts the job without a done.
      load_job(3, 6);
      s_stall = 1'b0;
      t_stall = 1'b0;
      s_len   = LW'(3);
      t_len   = LW'(6);
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (t_val_cnt >= 2) break;
      end
      check("abort_reached_t", (t_val_cnt >= 2) ? 32'd1 : 32'd0, 1);
      reset_i = 1'b0;
      #1 check("reset_mid_job_outputs", out_vec(), 0);
      repeat (2) @(posedge clk);
      #1;
      s_src.delete();
      t_src.delete();
      s_exp.delete();
      t_exp.delete();
      reset_i  = 1'b1;
      exp_jobs = 0;
      @(posedge clk);
      #1;
      check("abort_no_done", done_cnt, 0);
      run_job(4, 6, 1'b0, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
